ysyx_25020037_gu: RTL
=====================

Name: ysyx_25020037_gu

Overview:
- Commit/update unit at the far end of the writeback bus; consumes the WBU's registered commit packet.
- Owns the RV32E GPR file (16 x 32) and the four machine CSRs: mstatus, mtvec, mepc, mcause.
- Applies the GPR write, the CSR write and ecall/mret trap side effects.
- Hands the next PC to the IFU through a valid/ready handshake; the GPR and CSR read ports serve the IDU/EXU.

Parameters:
- NR_GPR, 16, number of architectural GPRs; x0 reads as zero.
- MSTATUS_RST, 32'h0000_1800, mstatus value at reset (MPP=11).
- MCAUSE_ECALL, 32'd11, mcause value written on ecall from M-mode.

Ports:
- clk  in  1  the single clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- wbu_valid  in  1  one-cycle pulse: wu_to_gu_bus holds a commit packet.
- wu_to_gu_bus  in  WU_TO_GU_BUS_WD  packet, MSB first: pc[29:0], rd[3:0], ecall_en, mret_en, eu_to_gu_bus{csr_we, csr_idx[1:0], dnpc[29:0]}, csr_wdata[31:0], gpr_we, result[31:0].
- gu_busy  out  1  a redirect is pending; the upstream must not pulse wbu_valid.
- gu_valid  out  1  next PC available for the IFU.
- gu_npc  out  30  word-aligned next PC.
- ifu_ready  in  1  IFU accepts gu_npc.
- rs1_idx, rs2_idx  in  4 each  GPR read addresses.
- rs1_data, rs2_data  out  32 each  combinational read data.
- csr_ridx  in  2  CSR read select: 0 mstatus, 1 mtvec, 2 mepc, 3 mcause.
- csr_rdata  out  32  combinational CSR read data.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - all GPRs 0; mtvec, mepc, mcause 0; mstatus = MSTATUS_RST.
  - FSM in IDLE; gu_valid 0; gu_npc 0; gu_busy 0.
- FSM has two states, IDLE and REDIRECT.
  - IDLE, wbu_valid=1: commit at this edge, then go to REDIRECT. gu_valid and gu_busy rise the next cycle.
  - REDIRECT: hold gu_valid=1 and gu_npc stable until gu_valid && ifu_ready. Return to IDLE at that edge; gu_valid drops the following cycle.
  - REDIRECT, wbu_valid=1: protocol violation. The packet is ignored (no architectural update). The simulation assertion fires.
- Commit actions, all at one edge:
  - GPR write: if gpr_we && rd!=0, GPR[rd] <= result. rd=0 writes are dropped.
  - CSR write: if csr_we, CSR[csr_idx] <= csr_wdata.
  - ecall_en:
    - mepc <= {pc,2'b00}; mcause <= MCAUSE_ECALL.
    - mstatus.MPIE <= MIE, MIE <= 0, MPP <= 2'b11.
    - gu_npc <= mtvec[31:2], using the pre-commit value.
  - mret_en:
    - mstatus.MIE <= MPIE, MPIE <= 1.
    - gu_npc <= mepc[31:2], using the pre-commit value.
  - Otherwise gu_npc <= dnpc.
  - Priority for the same CSR: trap side effects override the csr_we write. ecall_en && mret_en together is illegal and asserted; ecall wins.
- Reads: rs*_data = 0 when idx==0. No same-cycle write bypass: a read during the write edge returns the old value.
- Reset mid-REDIRECT: clears immediately to the reset state; the pending npc is lost.

Optional Feature:
- Macro: YSYX_25020037_GU_BYPASS_EN.
- Defined:
  - rs1_data/rs2_data return result when wbu_valid && gpr_we && rd==idx && rd!=0 in the same cycle.
  - csr_rdata returns csr_wdata when wbu_valid && csr_we && csr_idx==csr_ridx (trap side effects not bypassed).
- Undefined: pure register-file reads as above.

Decomposition:
- Shared config header (existing): WU_TO_GU_BUS_WD, EU_TO_GU_BUS_WD, field offsets, CSR index constants (CSR_MSTATUS=0, CSR_MTVEC=1, CSR_MEPC=2, CSR_MCAUSE=3), mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
- One natural sub-module, ysyx_25020037_gu_regfile: 16x32 GPR array, synchronous write, two async read ports, x0 hardwired. CSRs and the FSM stay in the top module.

Test Plan:
- Reset, then idle: rs1_idx=5 -> rs1_data=0; csr_ridx=0 -> 0x1800; gu_valid=0.
- Commit gpr_we=1, rd=3, result=0xDEADBEEF, dnpc=0x2000_0001:
  - next cycle gu_valid=1, gu_npc=0x2000_0001; rs1_idx=3 reads 0xDEADBEEF.
  - ifu_ready held 0 for 3 cycles -> gu_valid and gu_npc stable; ready=1 -> IDLE.
- Commit rd=0, result=0x1234 -> x0 still reads 0.
- csr_we to mtvec with 0x8000_0100, then ecall at pc=0x2000_0010:
  - mepc=0x8000_0040; mcause=11; mstatus.MIE=0, MPP=3.
  - gu_npc=0x2000_0040.
- mret after the ecall -> gu_npc=0x2000_0010; mstatus.MPIE=1; MIE equals the old MPIE.
- rst pulled low while in REDIRECT -> gu_valid=0 immediately; all state at reset values.
- With YSYX_25020037_GU_BYPASS_EN: same-cycle write of rd=7 and read of rs2_idx=7 -> new value; without the macro -> old value.

Source files
------------

// File: rtl/ysyx_25020037_gu_pkg.sv
// Shared definitions for the commit/update unit: commit packet layout, CSR indices, mstatus fields, FSM states.
// Optional feature macro used by the top: YSYX_25020037_GU_BYPASS_EN.
package ysyx_25020037_gu_pkg;

    localparam int          NR_GPR       = 16;
    localparam logic [31:0] MSTATUS_RST  = 32'h0000_1800;
    localparam logic [31:0] MCAUSE_ECALL = 32'd11;

    localparam logic [1:0] CSR_MSTATUS = 2'd0;
    localparam logic [1:0] CSR_MTVEC   = 2'd1;
    localparam logic [1:0] CSR_MEPC    = 2'd2;
    localparam logic [1:0] CSR_MCAUSE  = 2'd3;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // EXU-originated part of the commit packet
    typedef struct packed {
        logic        csr_we;
        logic [1:0]  csr_idx;
        logic [29:0] dnpc;
    } eu_to_gu_t;

    // Full commit packet, MSB first
    typedef struct packed {
        logic [29:0] pc;
        logic [3:0]  rd;
        logic        ecall_en;
        logic        mret_en;
        eu_to_gu_t   eu;
        logic [31:0] csr_wdata;
        logic        gpr_we;
        logic [31:0] result;
    } wu_to_gu_t;

    localparam int EU_TO_GU_BUS_WD = $bits(eu_to_gu_t);
    localparam int WU_TO_GU_BUS_WD = $bits(wu_to_gu_t);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } gu_state_e;

endpackage

// File: rtl/ysyx_25020037_gu_regfile.sv
// RV32E general-purpose register file: 16x32, one synchronous write port, two combinational read ports.
// Latency: write visible the cycle after the edge; reads are combinational. No backpressure.
module ysyx_25020037_gu_regfile
    import ysyx_25020037_gu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  rs1_idx,
    input  logic [3:0]  rs2_idx,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data
);

    logic [31:0] regs [0:NR_GPR-1];

    // Entry 0 is never written, so x0 stays zero without special read logic in the array
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR_GPR; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 4'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rs1_data = (rs1_idx == 4'd0) ? 32'd0 : regs[rs1_idx];
    assign rs2_data = (rs2_idx == 4'd0) ? 32'd0 : regs[rs2_idx];

endmodule

// File: rtl/ysyx_25020037_gu.sv
// Commit/update unit: applies GPR/CSR writes and ecall/mret trap effects, then offers the next PC to the IFU.
// Latency: gu_valid one cycle after wbu_valid; holds until ifu_ready. Busy while redirecting. Macro: YSYX_25020037_GU_BYPASS_EN.
module ysyx_25020037_gu
    import ysyx_25020037_gu_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wbu_valid,
    input  logic [WU_TO_GU_BUS_WD-1:0] wu_to_gu_bus,
    output logic                       gu_busy,
    output logic                       gu_valid,
    output logic [29:0]                gu_npc,
    input  logic                       ifu_ready,
    input  logic [3:0]                 rs1_idx,
    input  logic [3:0]                 rs2_idx,
    output logic [31:0]                rs1_data,
    output logic [31:0]                rs2_data,
    input  logic [1:0]                 csr_ridx,
    output logic [31:0]                csr_rdata
);

    wu_to_gu_t pkt;
    assign pkt = wu_to_gu_t'(wu_to_gu_bus);

    gu_state_e state_q, state_d;
    logic      commit;

    // A packet arriving while a redirect is pending is a protocol violation and is dropped
    assign commit = wbu_valid && (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (wbu_valid) state_d = ST_REDIRECT;
            ST_REDIRECT: if (ifu_ready) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    assign gu_valid = (state_q == ST_REDIRECT);
    assign gu_busy  = (state_q == ST_REDIRECT);

    logic [31:0] mstatus_q, mtvec_q, mepc_q, mcause_q;
    logic [31:0] mstatus_d, mtvec_d, mepc_d, mcause_d;
    logic [29:0] npc_d;

    // Trap effects are applied after the explicit CSR write so they win on the same register;
    // all trap sources (mtvec, mepc, old MIE/MPIE) use pre-commit values.
    always_comb begin
        mstatus_d = mstatus_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        npc_d     = gu_npc;
        if (commit) begin
            if (pkt.eu.csr_we) begin
                case (pkt.eu.csr_idx)
                    CSR_MSTATUS: mstatus_d = pkt.csr_wdata;
                    CSR_MTVEC:   mtvec_d   = pkt.csr_wdata;
                    CSR_MEPC:    mepc_d    = pkt.csr_wdata;
                    default:     mcause_d  = pkt.csr_wdata;
                endcase
            end
            if (pkt.ecall_en) begin
                mepc_d                                     = {pkt.pc, 2'b00};
                mcause_d                                   = MCAUSE_ECALL;
                mstatus_d[MSTATUS_MPIE]                    = mstatus_q[MSTATUS_MIE];
                mstatus_d[MSTATUS_MIE]                     = 1'b0;
                mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = 2'b11;
                npc_d                                      = mtvec_q[31:2];
            end else if (pkt.mret_en) begin
                mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
                mstatus_d[MSTATUS_MPIE] = 1'b1;
                npc_d                   = mepc_q[31:2];
            end else begin
                npc_d = pkt.eu.dnpc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_q <= MSTATUS_RST;
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
            gu_npc    <= '0;
        end else begin
            mstatus_q <= mstatus_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            gu_npc    <= npc_d;
        end
    end

    logic [31:0] rf_rs1, rf_rs2, csr_q_rdata;

    ysyx_25020037_gu_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (commit && pkt.gpr_we),
        .waddr    (pkt.rd),
        .wdata    (pkt.result),
        .rs1_idx  (rs1_idx),
        .rs2_idx  (rs2_idx),
        .rs1_data (rf_rs1),
        .rs2_data (rf_rs2)
    );

    always_comb begin
        case (csr_ridx)
            CSR_MSTATUS: csr_q_rdata = mstatus_q;
            CSR_MTVEC:   csr_q_rdata = mtvec_q;
            CSR_MEPC:    csr_q_rdata = mepc_q;
            default:     csr_q_rdata = mcause_q;
        endcase
    end

`ifdef YSYX_25020037_GU_BYPASS_EN
    logic gpr_byp, csr_byp;
    assign gpr_byp   = wbu_valid && pkt.gpr_we && (pkt.rd != 4'd0);
    assign csr_byp   = wbu_valid && pkt.eu.csr_we && (pkt.eu.csr_idx == csr_ridx);
    assign rs1_data  = (gpr_byp && (pkt.rd == rs1_idx)) ? pkt.result : rf_rs1;
    assign rs2_data  = (gpr_byp && (pkt.rd == rs2_idx)) ? pkt.result : rf_rs2;
    assign csr_rdata = csr_byp ? pkt.csr_wdata : csr_q_rdata;
`else
    assign rs1_data  = rf_rs1;
    assign rs2_data  = rf_rs2;
    assign csr_rdata = csr_q_rdata;
`endif

    a_no_commit_while_busy: assert property (@(posedge clk) disable iff (!rst)
        !(wbu_valid && (state_q == ST_REDIRECT)));

    a_no_ecall_and_mret: assert property (@(posedge clk) disable iff (!rst)
        !(wbu_valid && pkt.ecall_en && pkt.mret_en));

endmodule
